// File: rtl/lif_neuron_if.sv
// Bus bundle for one lif_neuron: timestep/spike inputs, weight write port and neuron outputs.
// The layer controller uses the master modport; the neuron uses the slave modport.
interface lif_neuron_if #(
  parameter int NUM_INPUTS  = 4,
  parameter int WEIGHT_SIZE = 8,
  parameter int POT_SIZE    = 16
);
  localparam int AW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  logic                          step;
  logic [NUM_INPUTS-1:0]         spike_in;
  logic                          wr_en;
  logic [AW-1:0]                 wr_addr;
  logic signed [WEIGHT_SIZE-1:0] wr_data;
  logic                          spike_out;
  logic signed [POT_SIZE-1:0]    potential;
  logic                          refrac_active;

  modport master (
    output step, spike_in, wr_en, wr_addr, wr_data,
    input  spike_out, potential, refrac_active
  );

  modport slave (
    input  step, spike_in, wr_en, wr_addr, wr_data,
    output spike_out, potential, refrac_active
  );
endinterface

// File: rtl/lif_neuron.sv
// Clocked integrate-and-fire neuron with saturating potential, refractory hold-off and writable weights.
// Optional leak toward zero is enabled by defining LIF_NEURON_LEAK_EN.
module lif_neuron #(
  parameter int NUM_INPUTS  = 4,
  parameter int WEIGHT_SIZE = 8,
  parameter int POT_SIZE    = 16,
  parameter int THRESH      = 10,
  parameter int RESET       = 0,
  parameter int REFRAC      = 2,
  parameter int LEAK        = 1
) (
  input logic         i_clk,
  input logic         i_rst,
  lif_neuron_if.slave io_bus
);
  // state | meaning
  // ST_NORMAL     | steps integrate weighted spikes and may fire
  // ST_REFRACTORY | steps only count down the hold-off, potential frozen
  typedef enum logic {ST_NORMAL, ST_REFRACTORY} state_t;

  localparam int AW  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int CLG = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 0;
  localparam int CW  = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  // Internal width holds the full weighted sum even if POT_SIZE is narrower than the sum range.
  localparam int EW  = ((POT_SIZE > WEIGHT_SIZE + CLG) ? POT_SIZE : WEIGHT_SIZE + CLG) + 2;

  localparam logic signed [POT_SIZE-1:0] P_MAX_N = {1'b0, {(POT_SIZE-1){1'b1}}};
  localparam logic signed [POT_SIZE-1:0] P_MIN_N = {1'b1, {(POT_SIZE-1){1'b0}}};
  localparam logic signed [EW-1:0]       P_MAX   = EW'(P_MAX_N);
  localparam logic signed [EW-1:0]       P_MIN   = EW'(P_MIN_N);
  localparam logic signed [EW-1:0]       THR     = EW'(THRESH);
  localparam logic signed [POT_SIZE-1:0] RST_V   = POT_SIZE'(RESET);
  localparam logic [AW:0]                NI      = (AW+1)'(NUM_INPUTS);

  state_t                        r_state, w_state_nxt;
  logic signed [WEIGHT_SIZE-1:0] r_weight [NUM_INPUTS];
  logic signed [POT_SIZE-1:0]    r_pot, w_pot_nxt;
  logic [CW-1:0]                 r_cnt, w_cnt_nxt;
  logic                          r_spike, w_spike_nxt;
  logic signed [EW-1:0]          w_sum, w_pot_ext, w_base, w_raw, w_sat;
  logic                          w_fire;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (io_bus.spike_in[i]) w_sum = w_sum + EW'(r_weight[i]);
    end
  end

  assign w_pot_ext = EW'(r_pot);

`ifdef LIF_NEURON_LEAK_EN
  localparam logic signed [EW-1:0] LEAK_V = EW'(LEAK);

  // Leak pulls toward zero but never past it.
  always_comb begin
    if (w_pot_ext > LEAK_V)       w_base = w_pot_ext - LEAK_V;
    else if (w_pot_ext < -LEAK_V) w_base = w_pot_ext + LEAK_V;
    else                          w_base = '0;
  end
`else
  logic [31:0] w_unused_leak;
  assign w_unused_leak = LEAK;
  assign w_base        = w_pot_ext;
`endif

  always_comb begin
    w_raw = w_base + w_sum;
    if (w_raw > P_MAX)      w_sat = P_MAX;
    else if (w_raw < P_MIN) w_sat = P_MIN;
    else                    w_sat = w_raw;
    w_fire = (w_sat >= THR);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pot_nxt   = r_pot;
    w_cnt_nxt   = r_cnt;
    w_spike_nxt = 1'b0;
    case (r_state)
      ST_NORMAL: begin
        if (io_bus.step) begin
          if (w_fire) begin
            w_pot_nxt   = RST_V;
            w_spike_nxt = 1'b1;
            if (REFRAC > 0) begin
              w_state_nxt = ST_REFRACTORY;
              w_cnt_nxt   = CW'(REFRAC);
            end
          end else begin
            w_pot_nxt = w_sat[POT_SIZE-1:0];
          end
        end
      end
      ST_REFRACTORY: begin
        if (io_bus.step) begin
          if (r_cnt <= CW'(1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_NORMAL;
          end else begin
            w_cnt_nxt = r_cnt - CW'(1);
          end
        end
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= ST_NORMAL;
      r_pot   <= '0;
      r_cnt   <= '0;
      r_spike <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pot   <= w_pot_nxt;
      r_cnt   <= w_cnt_nxt;
      r_spike <= w_spike_nxt;
    end
  end

  // Weights update after the integration of the same edge, so a coincident step sees the old value.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < NUM_INPUTS; i++) r_weight[i] <= WEIGHT_SIZE'(1);
    end else if (io_bus.wr_en && ({1'b0, io_bus.wr_addr} < NI)) begin
      r_weight[io_bus.wr_addr] <= io_bus.wr_data;
    end
  end

  assign io_bus.spike_out     = r_spike;
  assign io_bus.potential     = r_pot;
  assign io_bus.refrac_active = (r_state == ST_REFRACTORY);
endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: default instance driven from a vector table, plus a narrow
// 8-bit-potential instance for saturation and back-to-back firing.
module tb_lif_neuron;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  lif_neuron_if #(.NUM_INPUTS(4), .WEIGHT_SIZE(8), .POT_SIZE(16)) bus_a ();
  lif_neuron_if #(.NUM_INPUTS(4), .WEIGHT_SIZE(8), .POT_SIZE(8))  bus_b ();

  lif_neuron #(
    .NUM_INPUTS(4), .WEIGHT_SIZE(8), .POT_SIZE(16), .THRESH(10),
    .RESET(0), .REFRAC(2), .LEAK(1)
  ) u_a (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus_a)
  );

  lif_neuron #(
    .NUM_INPUTS(4), .WEIGHT_SIZE(8), .POT_SIZE(8), .THRESH(127),
    .RESET(0), .REFRAC(0), .LEAK(1)
  ) u_b (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus_b)
  );

  typedef struct {
    logic              step;
    logic [3:0]        spk;
    logic              wr;
    logic [1:0]        addr;
    logic signed [7:0] data;
    logic              e_spk;
    int                e_pot;
    logic              e_ref;
  } vec_t;

  localparam int NV = 23;
  vec_t va [NV];

  task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_a(input string nm, input logic e_spk, input int e_pot, input logic e_ref);
    check({nm, "_spike"},  {31'b0, bus_a.spike_out},     {31'b0, e_spk});
    check({nm, "_pot"},    bus_a.potential,              e_pot);
    check({nm, "_refrac"}, {31'b0, bus_a.refrac_active}, {31'b0, e_ref});
  endtask

  task automatic check_b(input string nm, input logic e_spk, input int e_pot);
    check({nm, "_spike"}, {31'b0, bus_b.spike_out}, {31'b0, e_spk});
    check({nm, "_pot"},   bus_b.potential,          e_pot);
    check({nm, "_refrac"}, {31'b0, bus_b.refrac_active}, 0);
  endtask

  task automatic cyc_a(input logic st, input logic [3:0] spk, input logic wr,
                       input logic [1:0] addr, input logic signed [7:0] data);
    bus_a.step = st; bus_a.spike_in = spk; bus_a.wr_en = wr;
    bus_a.wr_addr = addr; bus_a.wr_data = data;
    @(posedge clk); #1;
    bus_a.step = 1'b0; bus_a.spike_in = '0; bus_a.wr_en = 1'b0;
  endtask

  task automatic cyc_b(input logic st, input logic [3:0] spk, input logic wr,
                       input logic [1:0] addr, input logic signed [7:0] data);
    bus_b.step = st; bus_b.spike_in = spk; bus_b.wr_en = wr;
    bus_b.wr_addr = addr; bus_b.wr_data = data;
    @(posedge clk); #1;
    bus_b.step = 1'b0; bus_b.spike_in = '0; bus_b.wr_en = 1'b0;
  endtask

  initial begin
    va[0]  = '{1'b1, 4'b0011, 1'b0, 2'd0,  8'sd0,  1'b0, 2, 1'b0};
    va[1]  = '{1'b1, 4'b0011, 1'b0, 2'd0,  8'sd0,  1'b0, 4, 1'b0};
    va[2]  = '{1'b1, 4'b0011, 1'b0, 2'd0,  8'sd0,  1'b0, 6, 1'b0};
    va[3]  = '{1'b1, 4'b0011, 1'b0, 2'd0,  8'sd0,  1'b0, 8, 1'b0};
    va[4]  = '{1'b1, 4'b0011, 1'b0, 2'd0,  8'sd0,  1'b1, 0, 1'b1};
    va[5]  = '{1'b0, 4'b0000, 1'b0, 2'd0,  8'sd0,  1'b0, 0, 1'b1};
    va[6]  = '{1'b1, 4'b1111, 1'b0, 2'd0,  8'sd0,  1'b0, 0, 1'b1};
    va[7]  = '{1'b1, 4'b1111, 1'b0, 2'd0,  8'sd0,  1'b0, 0, 1'b0};
    va[8]  = '{1'b1, 4'b1111, 1'b0, 2'd0,  8'sd0,  1'b0, 4, 1'b0};
    va[9]  = '{1'b0, 4'b0000, 1'b0, 2'd0,  8'sd0,  1'b0, 4, 1'b0};
    va[10] = '{1'b0, 4'b0000, 1'b1, 2'd0, -8'sd3,  1'b0, 4, 1'b0};
    va[11] = '{1'b1, 4'b0001, 1'b0, 2'd0,  8'sd0,  1'b0, 1, 1'b0};
    va[12] = '{1'b0, 4'b0000, 1'b1, 2'd2, -8'sd3,  1'b0, 1, 1'b0};
    va[13] = '{1'b1, 4'b0100, 1'b0, 2'd0,  8'sd0,  1'b0, -2, 1'b0};
    va[14] = '{1'b1, 4'b0010, 1'b1, 2'd1,  8'sd5,  1'b0, -1, 1'b0};
    va[15] = '{1'b1, 4'b0010, 1'b0, 2'd0,  8'sd0,  1'b0, 4, 1'b0};
    va[16] = '{1'b0, 4'b1111, 1'b0, 2'd0,  8'sd0,  1'b0, 4, 1'b0};
    va[17] = '{1'b1, 4'b0010, 1'b0, 2'd0,  8'sd0,  1'b0, 9, 1'b0};
    va[18] = '{1'b1, 4'b0001, 1'b0, 2'd0,  8'sd0,  1'b0, 6, 1'b0};
    va[19] = '{1'b1, 4'b0001, 1'b0, 2'd0,  8'sd0,  1'b0, 3, 1'b0};
    va[20] = '{1'b1, 4'b0110, 1'b0, 2'd0,  8'sd0,  1'b0, 5, 1'b0};
    va[21] = '{1'b0, 4'b0000, 1'b0, 2'd0,  8'sd0,  1'b0, 5, 1'b0};
    va[22] = '{1'b1, 4'b0000, 1'b0, 2'd0,  8'sd0,  1'b0, 5, 1'b0};

    bus_a.step = 1'b0; bus_a.spike_in = '0; bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_b.step = 1'b0; bus_b.spike_in = '0; bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_a("reset", 1'b0, 0, 1'b0);
    check_b("reset_b", 1'b0, 0);
    rst = 1'b1;

`ifdef LIF_NEURON_LEAK_EN
    cyc_a(1'b0, 4'b0000, 1'b1, 2'd0, 8'sd5);
    cyc_a(1'b1, 4'b0001, 1'b0, 2'd0, 8'sd0);
    check_a("leak_load5", 1'b0, 5, 1'b0);
    cyc_a(1'b1, 4'b0000, 1'b0, 2'd0, 8'sd0);
    check_a("leak_5to4", 1'b0, 4, 1'b0);
    cyc_a(1'b0, 4'b0000, 1'b1, 2'd0, -8'sd4);
    check_a("leak_idle", 1'b0, 4, 1'b0);
    cyc_a(1'b1, 4'b0001, 1'b0, 2'd0, 8'sd0);
    check_a("leak_then_neg", 1'b0, -1, 1'b0);
    cyc_a(1'b1, 4'b0000, 1'b0, 2'd0, 8'sd0);
    check_a("leak_neg1_to0", 1'b0, 0, 1'b0);
    cyc_a(1'b1, 4'b0000, 1'b0, 2'd0, 8'sd0);
    check_a("leak_zero_stays", 1'b0, 0, 1'b0);
    cyc_a(1'b0, 4'b0000, 1'b1, 2'd0, 8'sd3);
    cyc_a(1'b1, 4'b0001, 1'b0, 2'd0, 8'sd0);
    check_a("leak_load3", 1'b0, 3, 1'b0);
    cyc_a(1'b0, 4'b0000, 1'b0, 2'd0, 8'sd0);
    check_a("leak_nostep", 1'b0, 3, 1'b0);
    cyc_a(1'b1, 4'b0000, 1'b0, 2'd0, 8'sd0);
    check_a("leak_3to2", 1'b0, 2, 1'b0);
`else
    for (int k = 0; k < NV; k++) begin
      cyc_a(va[k].step, va[k].spk, va[k].wr, va[k].addr, va[k].data);
      check_a($sformatf("vec%0d", k), va[k].e_spk, va[k].e_pot, va[k].e_ref);
    end

    // Fire, then reset while the pulse and refractory are both active.
    cyc_a(1'b1, 4'b0010, 1'b0, 2'd0, 8'sd0);
    check_a("fire_at_10", 1'b1, 0, 1'b1);
    rst = 1'b0;
    cyc_a(1'b1, 4'b1111, 1'b1, 2'd0, 8'sd50);
    check_a("rst_mid_refrac", 1'b0, 0, 1'b0);
    cyc_a(1'b1, 4'b1111, 1'b1, 2'd1, 8'sd50);
    check_a("rst_hold", 1'b0, 0, 1'b0);
    rst = 1'b1;
    cyc_a(1'b1, 4'b0001, 1'b0, 2'd0, 8'sd0);
    check_a("post_rst_w0", 1'b0, 1, 1'b0);
    cyc_a(1'b1, 4'b1111, 1'b0, 2'd0, 8'sd0);
    check_a("post_rst_all", 1'b0, 5, 1'b0);

    // Narrow potential: positive saturation fires, REFRAC=0 allows back-to-back fires.
    cyc_b(1'b0, 4'b0000, 1'b1, 2'd0, 8'sd100);
    cyc_b(1'b1, 4'b0001, 1'b0, 2'd0, 8'sd0);
    check_b("sat_load100", 1'b0, 100);
    for (int i = 0; i < 4; i++) cyc_b(1'b0, 4'b0000, 1'b1, 2'(i), 8'sd127);
    cyc_b(1'b1, 4'b1111, 1'b0, 2'd0, 8'sd0);
    check_b("sat_fire", 1'b1, 0);
    cyc_b(1'b1, 4'b0001, 1'b0, 2'd0, 8'sd0);
    check_b("refrac0_refire", 1'b1, 0);
    cyc_b(1'b0, 4'b0000, 1'b0, 2'd0, 8'sd0);
    check_b("pulse_drop", 1'b0, 0);
    for (int i = 0; i < 4; i++) cyc_b(1'b0, 4'b0000, 1'b1, 2'(i), -8'sd128);
    cyc_b(1'b1, 4'b1111, 1'b0, 2'd0, 8'sd0);
    check_b("neg_clamp1", 1'b0, -128);
    cyc_b(1'b1, 4'b1111, 1'b0, 2'd0, 8'sd0);
    check_b("neg_clamp2", 1'b0, -128);
    cyc_b(1'b1, 4'b0000, 1'b0, 2'd0, 8'sd0);
    check_b("neg_hold", 1'b0, -128);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Clocked, parametrised integrate-and-fire neuron for the SNN fabric; successor to the combinational-accumulate neuron.
- Per timestep: sums signed per-input weights of active spike inputs into a saturating membrane potential, fires on threshold, resets and holds off for a refractory period.
- Weights are runtime-writable through a simple write port.
- One instance per neuron in a layer; layer controller drives the step strobe.

Parameters:
- NUM_INPUTS, 4, number of spike inputs (>=1)
- WEIGHT_SIZE, 8, signed weight width
- POT_SIZE, 16, signed potential width (>= WEIGHT_SIZE + clog2(NUM_INPUTS))
- THRESH, 10, firing threshold (signed, compared >=)
- RESET, 0, potential value loaded after a spike
- REFRAC, 2, refractory length in timesteps (0 = none)
- LEAK, 1, per-step leak magnitude (used only with LEAK_EN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- step  in  1  timestep strobe; one integration per high cycle
- spike_in  in  NUM_INPUTS  spike vector, sampled when step=1
- wr_en  in  1  weight write enable
- wr_addr  in  clog2(NUM_INPUTS) (min 1)  weight index
- wr_data  in  WEIGHT_SIZE  signed weight value
- spike_out  out  1  one-cycle fire pulse
- potential  out  POT_SIZE  current membrane potential (signed)
- refrac_active  out  1  high while in REFRACTORY

Behaviour:
- Reset (rst=0 at posedge): potential=0, spike_out=0, refrac_active=0, refractory counter=0, state=NORMAL, all weights=1. wr_en and step are ignored during reset.
- States:
  - NORMAL: on step, integrate.
  - REFRACTORY: on step, decrement counter; no integration; spike_in ignored.
- Integration: sum = sum over i of (spike_in[i] ? sign-extended weight[i] : 0). next = potential + sum, computed at POT_SIZE+1 bits and saturated to [-2^(POT_SIZE-1), 2^(POT_SIZE-1)-1].
- Fire rule: if next >= THRESH, then at the same edge:
  - potential <= RESET
  - spike_out <= 1 for exactly one cycle
  - if REFRAC>0: state <= REFRACTORY, counter <= REFRAC
  - else: stay in NORMAL
- Otherwise: potential <= next, spike_out <= 0.
- Latency: spike_out asserts on the clock edge that samples step (registered, 1 cycle after step is presented).
- spike_out is 0 in every cycle with step=0.
- REFRACTORY exit: the step that decrements the counter 1->0 returns state to NORMAL at that edge. The following step integrates normally, so exactly REFRAC steps are blocked. refrac_active mirrors state.
- Potential is held (no change) throughout REFRACTORY and on cycles with step=0.
- Weight write: on wr_en=1, weight[wr_addr] <= wr_data.
  - Out-of-range wr_addr (>= NUM_INPUTS) is ignored.
  - Write coincident with step: the integration uses the old weight; the new weight takes effect from the next step.
- Negative weights (inhibition) are allowed; potential may go negative and saturates at the minimum.
- Reset mid-refractory or mid-pulse: immediate return to reset values at that edge.

Optional Feature:
- Macro: LIF_NEURON_LEAK_EN.
- Defined: on each NORMAL step, the leak is applied to the potential before summing:
  - potential > 0: subtract min(LEAK, potential)
  - potential < 0: add min(LEAK, -potential)
  - never crosses 0
- The threshold test uses the leaked value plus sum. No leak is applied in REFRACTORY or when step=0.
- Undefined: pure integrate-and-fire; the LEAK parameter is unused.

Test Plan:
- Reset/defaults: hold rst=0 3 cycles, release; step with spike_in=4'b0011 five times -> potential 2,4,6,8, then fire on 5th step (10>=10): spike_out one-cycle pulse, potential=0, refrac_active=1.
- Refractory: after the fire above with REFRAC=2, apply 2 steps with spike_in=4'b1111 -> potential stays 0, refrac_active falls after 2nd step; 3rd step -> potential=4.
- Weight write + inhibition: write weight[2]=-3; step with spike_in=4'b0100 from potential 1 -> potential=-2. Write coincident with step -> old weight used.
- Saturation: POT_SIZE=8, all weights 127, THRESH=127, RESET=0. From potential=100, step with 4'b1111 -> fire (saturated 127). Set THRESH beyond reach; driving negative weights repeatedly -> potential clamps at -128.
- Reset mid-operation: assert rst while refrac_active=1 and spike_out=1 -> next edge all outputs 0, weights back to 1.
- Leak (LIF_NEURON_LEAK_EN, LEAK=1): potential=5, step with spike_in=0 -> 4. Potential=-1, step with spike_in=0 -> 0 (no overshoot). Without macro -> 5 stays 5.
